bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter and slave-select controller for the serial system bus. It grants the shared bus to one master at a time using round-robin order. It then captures the slave ID that the granted master shifts onto the bus address line and drives a one-hot select to the slave ports, which are BRAM-backed. It sits between the master ports and the master-side bus multiplexer, and holds the grant until the owning master releases its request.

## Interface
- NUM_SLAVES, 3: number of slave ports; width of `slave_sel`.
- SEL_BITS, 2: slave-ID bits shifted serially, MSB first; requires 2^SEL_BITS >= NUM_SLAVES.
- SEL_TIMEOUT, 16: maximum cycles allowed in SELECT before the grant is revoked.

Ports:
- clk  in  1  bus clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- m1_req  in  1  master 1 bus request; level, held for the whole transaction.
- m2_req  in  1  master 2 bus request.
- addr_bit  in  1  muxed serial address line from the granted master.
- addr_valid  in  1  muxed `master_valid`; `addr_bit` is sampled only when this is high.
- m1_grant  out  1  master 1 owns the bus.
- m2_grant  out  1  master 2 owns the bus.
- master_sel  out  1  bus-mux select (0 = m1, 1 = m2); holds the last granted master.
- slave_sel  out  NUM_SLAVES  one-hot slave enable; valid only in ACTIVE.
- bus_busy  out  1  high whenever state is not IDLE.
- decode_err  out  1  one-cycle pulse when the captured ID is >= NUM_SLAVES.
- timeout  out  1  one-cycle pulse when SELECT times out.

## Operation
- States: IDLE, SELECT, ACTIVE, RELEASE.
- **IDLE:**
  - Any request moves to SELECT next cycle and asserts the chosen grant.
  - If only one master requests, that master is chosen.
  - If both request, the master not granted last is chosen.
  - The `last_grant` pointer resets to m2, so m1 wins the first tie.
- **SELECT:**
  - A shift register captures `addr_bit` on every `addr_valid` cycle; a bit counter runs 0..SEL_BITS-1.
  - On the cycle the last bit is sampled, the next state is ACTIVE.
  - If the decoded ID is < NUM_SLAVES, `slave_sel[ID]` is set to 1 on entry to ACTIVE.
  - Otherwise `slave_sel` stays 0 and `decode_err` pulses on the cycle of entry to ACTIVE.
  - If the granted master drops its request, go to RELEASE and discard the partial ID.
  - A cycle counter starts at 0 on entry to SELECT. When it reaches SEL_TIMEOUT-1 without completing the ID, `timeout` pulses and the next state is RELEASE.
  - The grant is revoked on timeout even if the request is still high.
- **ACTIVE:** grant and `slave_sel` are held. When the granted master's request is sampled low, go to RELEASE. The other master's request is ignored.
- **RELEASE:** grant, `slave_sel` and the counters clear. `last_grant` updates to the master just served. Next state is IDLE unconditionally.
- **Grant signals:** exactly one of `m1_grant`/`m2_grant` is high in SELECT and ACTIVE; both are low in IDLE and RELEASE.
- **Reset:** any state returns to IDLE immediately. All outputs are 0, `master_sel` is 0, `last_grant` is m2, and the shift register and counters are 0.

## Timing
- **Request to grant:** a request first sampled high at edge t gives grant high after edge t+1 (one cycle).
- **ID to select:** if the last ID bit is sampled at edge t, `slave_sel` is valid after edge t, i.e. in the same cycle that ACTIVE begins.
- **Request drop to grant low:** the request is sampled low at edge t; RELEASE begins after edge t, with grant low.
- **Turnaround:** the earliest next grant follows edge t+2, giving at least one dead cycle between owners.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Request in RELEASE:** a request that rises during RELEASE is served from IDLE on the next edge, with no loss.
- **Stalls:** `addr_valid` low in SELECT stalls the bit counter but not the timeout counter.

## Structure
- `bus_pkg` holds:
  - the state enum;
  - the master-ID constants (M1 = 0, M2 = 1);
  - the default SEL_BITS, NUM_SLAVES and SEL_TIMEOUT values.
- Sub-module `rr_pick2`: combinational two-requester round-robin pick, with inputs `req[1:0]` and `last` and outputs `pick` and `any`.
- Everything else lives in `bus_arbiter`: the FSM, ID shift register, bit counter, timeout counter, `last_grant`, and output registers.

## Test plan
- **Single master:** m1_req=1, then ID bits 1,0 on `addr_valid` → `m1_grant`=1 one cycle after the request; `slave_sel`=3'b100 after the second bit; m1_req=0 → grant low next cycle, `bus_busy` low one cycle later.
- **Simultaneous requests:** m1 and m2 request together from reset → m1 granted first; after m1 releases, m2 is granted after one dead cycle; a repeat tie is granted to m1 again.
- **Invalid ID:** m2 shifts ID 3 with NUM_SLAVES=3 → `decode_err` pulses once, `slave_sel`=0, `m2_grant` is held until m2_req drops.
- **Select timeout:** m1_req held with `addr_valid`=0 → `timeout` pulses 16 cycles after the grant; grant drops; a pending m2 is granted next.
- **Abort and reset:**
  - m1 drops its request after one ID bit → RELEASE, then IDLE, and `slave_sel` is never asserted.
  - Asserting `reset` in ACTIVE → all outputs are 0 immediately, without waiting for a clock edge.
- **Addr-valid gaps:** ID bits interleaved with `addr_valid` low cycles → the correct ID is still captured.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } bus_state_t;

  // Master identifiers; also the encoding of master_sel.
  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  localparam int unsigned DEF_NUM_SLAVES  = 3;
  localparam int unsigned DEF_SEL_BITS    = 2;
  localparam int unsigned DEF_SEL_TIMEOUT = 16;

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Combinational two-requester round-robin pick.
// req[0] is master 1, req[1] is master 2; on a tie the requester
// that was not served last wins.
module rr_pick2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick,
  output logic       any
);

  // Select the winner from the request pair and the last-served pointer.
  always_comb begin
    any  = req[0] | req[1];
    pick = M1;
    if (req[0] && req[1]) begin
      pick = ~last;
    end else if (req[1]) begin
      pick = M2;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with serial slave-ID capture
// and one-hot slave select. All outputs are registered.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int unsigned SEL_BITS    = DEF_SEL_BITS,
  parameter int unsigned SEL_TIMEOUT = DEF_SEL_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m1_req,
  input  logic                  m2_req,
  input  logic                  addr_bit,
  input  logic                  addr_valid,
  output logic                  m1_grant,
  output logic                  m2_grant,
  output logic                  master_sel,
  output logic [NUM_SLAVES-1:0] slave_sel,
  output logic                  bus_busy,
  output logic                  decode_err,
  output logic                  timeout
);

  localparam int unsigned BW = (SEL_BITS > 1)    ? $clog2(SEL_BITS)    : 1;
  localparam int unsigned TW = (SEL_TIMEOUT > 1) ? $clog2(SEL_TIMEOUT) : 1;

  bus_state_t            r_state;
  logic                  r_last_grant;
  logic [SEL_BITS-1:0]   r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic [TW-1:0]         r_tcnt;
  logic                  r_m1_grant;
  logic                  r_m2_grant;
  logic                  r_master_sel;
  logic [NUM_SLAVES-1:0] r_slave_sel;
  logic                  r_busy;
  logic                  r_decode_err;
  logic                  r_timeout;

  logic                  w_pick;
  logic                  w_any;
  logic                  w_own_req;
  logic                  w_last_bit;
  logic [SEL_BITS-1:0]   w_id;
  logic [NUM_SLAVES-1:0] w_onehot;

  rr_pick2 u_pick (
    .req  ({m2_req, m1_req}),
    .last (r_last_grant),
    .pick (w_pick),
    .any  (w_any)
  );

  // Derive the owner's request, the ID including the bit on the line, and its one-hot form.
  always_comb begin
    w_own_req  = (r_master_sel == M2) ? m2_req : m1_req;
    w_last_bit = addr_valid && (r_bit_cnt == BW'(SEL_BITS - 1));
    w_id       = SEL_BITS'({r_shift, addr_bit});
    w_onehot   = NUM_SLAVES'(1) << w_id;
  end

  // Arbitration FSM with ID capture, timeout counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= M2;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_tcnt       <= '0;
      r_m1_grant   <= 1'b0;
      r_m2_grant   <= 1'b0;
      r_master_sel <= M1;
      r_slave_sel  <= '0;
      r_busy       <= 1'b0;
      r_decode_err <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_decode_err <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state      <= ST_SELECT;
            r_master_sel <= w_pick;
            r_m1_grant   <= (w_pick == M1);
            r_m2_grant   <= (w_pick == M2);
            r_busy       <= 1'b1;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_tcnt       <= '0;
          end
        end
        ST_SELECT: begin
          // Priority: owner abort, then ID completion, then timeout.
          if (!w_own_req) begin
            r_state     <= ST_RELEASE;
            r_m1_grant  <= 1'b0;
            r_m2_grant  <= 1'b0;
            r_slave_sel <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_tcnt      <= '0;
          end else if (w_last_bit) begin
            r_state <= ST_ACTIVE;
            r_shift <= w_id;
            if (32'(w_id) < NUM_SLAVES) begin
              r_slave_sel <= w_onehot;
            end else begin
              r_decode_err <= 1'b1;
            end
          end else if (r_tcnt == TW'(SEL_TIMEOUT - 1)) begin
            r_state     <= ST_RELEASE;
            r_timeout   <= 1'b1;
            r_m1_grant  <= 1'b0;
            r_m2_grant  <= 1'b0;
            r_slave_sel <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_tcnt      <= '0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
            if (addr_valid) begin
              r_shift   <= w_id;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (!w_own_req) begin
            r_state     <= ST_RELEASE;
            r_m1_grant  <= 1'b0;
            r_m2_grant  <= 1'b0;
            r_slave_sel <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_tcnt      <= '0;
          end
        end
        ST_RELEASE: begin
          r_last_grant <= r_master_sel;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m1_grant   = r_m1_grant;
  assign m2_grant   = r_m2_grant;
  assign master_sel = r_master_sel;
  assign slave_sel  = r_slave_sel;
  assign bus_busy   = r_busy;
  assign decode_err = r_decode_err;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter.
// Observed vector order: {m1_grant, m2_grant, master_sel, slave_sel[2:0], bus_busy, decode_err, timeout}
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic       m1_req;
  logic       m2_req;
  logic       addr_bit;
  logic       addr_valid;
  logic       m1_grant;
  logic       m2_grant;
  logic       master_sel;
  logic [2:0] slave_sel;
  logic       bus_busy;
  logic       decode_err;
  logic       timeout;

  logic [8:0] obs;
  logic [8:0] exp;
  int         checks;
  int         failures;

  assign obs = {m1_grant, m2_grant, master_sel, slave_sel, bus_busy, decode_err, timeout};

  bus_arbiter #(.NUM_SLAVES(3), .SEL_BITS(2), .SEL_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .m1_req     (m1_req),
    .m2_req     (m2_req),
    .addr_bit   (addr_bit),
    .addr_valid (addr_valid),
    .m1_grant   (m1_grant),
    .m2_grant   (m2_grant),
    .master_sel (master_sel),
    .slave_sel  (slave_sel),
    .bus_busy   (bus_busy),
    .decode_err (decode_err),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; m1_req = 1'b0; m2_req = 1'b0; addr_bit = 1'b0; addr_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; m1_req = 1'b1; m2_req = 1'b1; addr_bit = 1'b1; addr_valid = 1'b1;
    tick();
    exp = 9'b0_0_0_000_0_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL reset_hold obs=%b exp=%b", obs, exp); end
    m1_req = 1'b0; m2_req = 1'b0; addr_bit = 1'b0; addr_valid = 1'b0;
    reset = 1'b0;
    tick();
    checks++; if (obs !== exp) begin failures++; $display("FAIL reset_idle obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_single_master();
    apply_reset();
    m1_req = 1'b1;
    tick(); exp = 9'b1_0_0_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL sm_grant obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b1; addr_bit = 1'b1;
    tick();
    checks++; if (obs !== exp) begin failures++; $display("FAIL sm_bit0 obs=%b exp=%b", obs, exp); end
    addr_bit = 1'b0;
    tick(); exp = 9'b1_0_0_100_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL sm_active obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b0; m1_req = 1'b0;
    tick(); exp = 9'b0_0_0_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL sm_release obs=%b exp=%b", obs, exp); end
    tick(); exp = 9'b0_0_0_000_0_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL sm_idle obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    m1_req = 1'b1; m2_req = 1'b1;
    tick(); exp = 9'b1_0_0_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL tie_first_m1 obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b1; addr_bit = 1'b0;
    tick();
    tick(); exp = 9'b1_0_0_001_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL tie_m1_sel0 obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b0; m1_req = 1'b0;
    tick(); exp = 9'b0_0_0_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL tie_m1_release obs=%b exp=%b", obs, exp); end
    tick(); exp = 9'b0_0_0_000_0_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL tie_dead_cycle obs=%b exp=%b", obs, exp); end
    tick(); exp = 9'b0_1_1_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL tie_m2_grant obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b1; addr_bit = 1'b0;
    tick();
    addr_bit = 1'b1;
    tick(); exp = 9'b0_1_1_010_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL tie_m2_sel1 obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b0; m2_req = 1'b0;
    tick(); exp = 9'b0_0_1_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL tie_m2_release obs=%b exp=%b", obs, exp); end
    // Both requests rise during RELEASE and must be served from IDLE.
    m1_req = 1'b1; m2_req = 1'b1;
    tick(); exp = 9'b0_0_1_000_0_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL tie_idle2 obs=%b exp=%b", obs, exp); end
    tick(); exp = 9'b1_0_0_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL tie_repeat_m1 obs=%b exp=%b", obs, exp); end
    m1_req = 1'b0; m2_req = 1'b0;
    tick(); exp = 9'b0_0_0_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL tie_final_release obs=%b exp=%b", obs, exp); end
    tick();
  endtask

  task automatic test_invalid_id();
    apply_reset();
    m2_req = 1'b1;
    tick(); exp = 9'b0_1_1_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL inv_grant obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b1; addr_bit = 1'b1;
    tick();
    tick(); exp = 9'b0_1_1_000_1_1_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL inv_decode_err obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b0;
    tick(); exp = 9'b0_1_1_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL inv_pulse_end obs=%b exp=%b", obs, exp); end
    tick();
    checks++; if (obs !== exp) begin failures++; $display("FAIL inv_hold obs=%b exp=%b", obs, exp); end
    m2_req = 1'b0;
    tick(); exp = 9'b0_0_1_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL inv_release obs=%b exp=%b", obs, exp); end
    tick(); exp = 9'b0_0_1_000_0_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL inv_idle obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_timeout();
    apply_reset();
    m1_req = 1'b1; m2_req = 1'b1; addr_valid = 1'b0;
    tick(); exp = 9'b1_0_0_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL to_grant obs=%b exp=%b", obs, exp); end
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++; if (obs !== exp) begin failures++; $display("FAIL to_wait cyc=%0d obs=%b exp=%b", i, obs, exp); end
    end
    tick(); exp = 9'b0_0_0_000_1_0_1;
    checks++; if (obs !== exp) begin failures++; $display("FAIL to_pulse obs=%b exp=%b", obs, exp); end
    tick(); exp = 9'b0_0_0_000_0_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL to_idle obs=%b exp=%b", obs, exp); end
    tick(); exp = 9'b0_1_1_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL to_m2_next obs=%b exp=%b", obs, exp); end
    m1_req = 1'b0; m2_req = 1'b0;
    tick(); exp = 9'b0_0_1_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL to_m2_release obs=%b exp=%b", obs, exp); end
    tick();
  endtask

  task automatic test_abort_and_reset();
    apply_reset();
    m1_req = 1'b1;
    tick();
    addr_valid = 1'b1; addr_bit = 1'b1;
    tick(); exp = 9'b1_0_0_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL ab_one_bit obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b0; m1_req = 1'b0;
    tick(); exp = 9'b0_0_0_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL ab_release obs=%b exp=%b", obs, exp); end
    tick(); exp = 9'b0_0_0_000_0_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL ab_idle obs=%b exp=%b", obs, exp); end
    // A fresh transaction must start its ID from scratch.
    m1_req = 1'b1;
    tick();
    addr_valid = 1'b1; addr_bit = 1'b0;
    tick(); exp = 9'b1_0_0_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL ab_fresh_bit0 obs=%b exp=%b", obs, exp); end
    addr_bit = 1'b1;
    tick(); exp = 9'b1_0_0_010_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL ab_fresh_active obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b0;
    reset = 1'b1;
    #1; exp = 9'b0_0_0_000_0_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL ab_async_reset obs=%b exp=%b", obs, exp); end
    m1_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (obs !== exp) begin failures++; $display("FAIL ab_post_reset obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_addr_gaps();
    apply_reset();
    m2_req = 1'b1;
    tick(); exp = 9'b0_1_1_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL gap_grant obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b1; addr_bit = 1'b1;
    tick();
    addr_valid = 1'b0; addr_bit = 1'b1;
    tick();
    checks++; if (obs !== exp) begin failures++; $display("FAIL gap_stall1 obs=%b exp=%b", obs, exp); end
    tick();
    checks++; if (obs !== exp) begin failures++; $display("FAIL gap_stall2 obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b1; addr_bit = 1'b0;
    tick(); exp = 9'b0_1_1_100_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL gap_active obs=%b exp=%b", obs, exp); end
    addr_valid = 1'b0; m1_req = 1'b1;
    tick();
    checks++; if (obs !== exp) begin failures++; $display("FAIL gap_other_ignored obs=%b exp=%b", obs, exp); end
    m2_req = 1'b0;
    tick(); exp = 9'b0_0_1_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL gap_release obs=%b exp=%b", obs, exp); end
    tick(); exp = 9'b0_0_1_000_0_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL gap_idle obs=%b exp=%b", obs, exp); end
    tick(); exp = 9'b1_0_0_000_1_0_0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL gap_m1_next obs=%b exp=%b", obs, exp); end
    m1_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; m1_req = 1'b0; m2_req = 1'b0; addr_bit = 1'b0; addr_valid = 1'b0;
    #1;
    test_reset();
    test_single_master();
    test_simultaneous();
    test_invalid_id();
    test_timeout();
    test_abort_and_reset();
    test_addr_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
